// File: rtl/temporal_pkg.sv
// temporal_pkg: shared types and helpers for the race-logic temporal encoder/decoder.
`default_nettype none

package temporal_pkg;

   localparam int unsigned TE_DEFAULT_GAMMA = 16;

   typedef enum logic [1:0] {
      TE_IDLE  = 2'd0,
      TE_WAIT  = 2'd1,
      TE_PULSE = 2'd2,
      TE_DONE  = 2'd3
   } te_state_t;

   function automatic int unsigned gamma_cnt_width(input int unsigned gamma);
      return (gamma > 1) ? $clog2(gamma) : 1;
   endfunction

   // Any value at or beyond the gamma-cycle length encodes "no event".
   function automatic logic is_inf(input int unsigned value, input int unsigned gamma);
      return (value >= gamma);
   endfunction

endpackage

`default_nettype wire

// File: rtl/gamma_counter.sv
// gamma_counter: time-slot counter, cleared by the gamma start strobe, saturating at the last slot.
`default_nettype none

module gamma_counter
   import temporal_pkg::*;
#(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   localparam int CW = gamma_cnt_width(GAMMA_CYCLE_WIDTH)
) (
   input  logic          aclk,
   input  logic          grst,
   input  logic          i_start,
   output logic [CW-1:0] o_t,
   output logic          o_last_slot
);

   logic [CW-1:0] r_t;

   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         r_t <= '0;
      end else if (i_start) begin
         r_t <= '0;
      end else if (!o_last_slot) begin
         r_t <= r_t + CW'(1);
      end
   end

   assign o_t         = r_t;
   assign o_last_slot = (r_t == CW'(GAMMA_CYCLE_WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/temporal_encoder.sv
// temporal_encoder: binary value -> single timed event per gamma cycle, with a one-entry pending buffer.
// Build option TE_LEVEL_HOLD_EN selects step (level-hold) encoding instead of fixed-width pulses.
`default_nettype none

module temporal_encoder
   import temporal_pkg::*;
#(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH       = 8,
   parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
   input  logic                   aclk,
   input  logic                   grst,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [VALUE_WIDTH-1:0] in_value,
   output logic                   q,
   output logic                   spiked,
   output logic                   busy
);

   localparam int CW  = gamma_cnt_width(GAMMA_CYCLE_WIDTH);
   localparam int PCW = $clog2(PULSE_WIDTH + 1);
   localparam logic [VALUE_WIDTH-1:0] c_INF = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH);

   te_state_t              r_state;
   logic                   r_pend_full;
   logic [VALUE_WIDTH-1:0] r_pend_val;
   logic [VALUE_WIDTH-1:0] r_active;
   logic [PCW-1:0]         r_pcnt;
   logic                   r_q;
   logic                   r_spiked;

   logic [CW-1:0]          w_t;
   logic                   w_last_slot;
   logic                   w_xfer;
   logic [VALUE_WIDTH-1:0] w_next_active;
   logic                   w_load_zero;
   logic                   w_fire;

   gamma_counter #(
      .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
   ) u_gamma_counter (
      .aclk       (aclk),
      .grst       (grst),
      .i_start    (rst),
      .o_t        (w_t),
      .o_last_slot(w_last_slot)
   );

   assign w_xfer        = in_valid && !r_pend_full;
   assign w_next_active = r_pend_full ? r_pend_val : c_INF;
   assign w_load_zero   = (w_next_active == '0);

   // q is registered, so the event is scheduled one slot early: fire when the next slot matches.
   assign w_fire = !w_last_slot
                && !is_inf(32'(r_active), GAMMA_CYCLE_WIDTH)
                && ((VALUE_WIDTH'(w_t) + VALUE_WIDTH'(1)) == r_active);

   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         r_state     <= TE_IDLE;
         r_pend_full <= 1'b0;
         r_pend_val  <= '0;
         r_active    <= c_INF;
         r_pcnt      <= '0;
         r_q         <= 1'b0;
         r_spiked    <= 1'b0;
      end else begin
         if (rst) begin
            r_active    <= w_next_active;
            r_pend_full <= 1'b0;
         end
         if (w_xfer) begin
            r_pend_full <= 1'b1;
            r_pend_val  <= in_value;
         end

         if (rst) begin
            r_spiked <= w_load_zero;
            r_q      <= w_load_zero;
            r_pcnt   <= PCW'(1);
            if (w_load_zero) begin
`ifdef TE_LEVEL_HOLD_EN
               r_state <= TE_DONE;
`else
               r_state <= TE_PULSE;
`endif
            end else begin
               r_state <= TE_WAIT;
            end
         end else begin
            case (r_state)
               TE_WAIT: begin
                  if (w_fire) begin
                     r_q      <= 1'b1;
                     r_spiked <= 1'b1;
                     r_pcnt   <= PCW'(1);
`ifdef TE_LEVEL_HOLD_EN
                     r_state  <= TE_DONE;
`else
                     r_state  <= TE_PULSE;
`endif
                  end else if (w_last_slot) begin
                     r_state <= TE_DONE;
                  end
               end
               TE_PULSE: begin
                  if (w_last_slot || (r_pcnt == PCW'(PULSE_WIDTH))) begin
                     r_q     <= 1'b0;
                     r_state <= TE_DONE;
                  end else begin
                     r_pcnt <= r_pcnt + PCW'(1);
                  end
               end
               default: begin
                  r_state <= r_state;
               end
            endcase
         end
      end
   end

   assign in_ready = !r_pend_full;
   assign q        = r_q;
   assign spiked   = r_spiked;
   assign busy     = (r_state == TE_WAIT) || (r_state == TE_PULSE);

endmodule

`default_nettype wire

// File: tb/tb_temporal_encoder.sv
// tb_temporal_encoder: directed self-checking bench for temporal_encoder (default 16-slot, 8-cycle pulse).
`default_nettype none

module tb_temporal_encoder;

`ifdef TE_LEVEL_HOLD_EN
   localparam bit LEVEL = 1'b1;
`else
   localparam bit LEVEL = 1'b0;
`endif

   logic       aclk = 1'b0;
   logic       grst;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_value;
   logic       q;
   logic       spiked;
   logic       busy;

   int tests = 0;
   int fails = 0;

   // Per-cycle samples after a rst: index k = cycles after the rst cycle C0.
   logic qh [0:31];
   logic sh [0:31];
   logic rh [0:31];
   logic bh [0:31];

   always #5 aclk = ~aclk;

   temporal_encoder dut (
      .aclk    (aclk),
      .grst    (grst),
      .rst     (rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_value(in_value),
      .q       (q),
      .spiked  (spiked),
      .busy    (busy)
   );

   // Reference model of the output timing for value v, k cycles after rst.
   function automatic int hi_k(input int v);
      if (LEVEL) return 1000;
      return (v + 8 < 16) ? v + 8 : 16;
   endfunction

   function automatic logic exp_q(input int k, input int v);
      if (v >= 16) return 1'b0;
      return (k >= v + 1) && (k <= hi_k(v));
   endfunction

   function automatic logic exp_spk(input int k, input int v);
      return (v < 16) && (k >= v + 1);
   endfunction

   function automatic logic exp_busy(input int k, input int v);
      if (v >= 16) return (k >= 1) && (k <= 16);
      if (LEVEL)   return (k >= 1) && (k <= v);
      return (k >= 1) && (k <= hi_k(v));
   endfunction

   task automatic do_load(input logic [4:0] v);
      in_valid = 1'b1;
      in_value = v;
      @(posedge aclk); #1;
      in_valid = 1'b0;
   endtask

   task automatic do_rst();
      rst = 1'b1;
      @(posedge aclk); #1;
      rst = 1'b0;
   endtask

   task automatic rst_capture(input int n, input logic xv, input logic [4:0] xval);
      rst      = 1'b1;
      in_valid = xv;
      in_value = xval;
      @(posedge aclk); #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(negedge aclk);
         qh[k] = q;
         sh[k] = spiked;
         rh[k] = in_ready;
         bh[k] = busy;
      end
      @(posedge aclk); #1;
   endtask

   task automatic test_reset();
      grst = 1'b1; rst = 1'b0; in_valid = 1'b0; in_value = '0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      tests++; if (q !== 1'b0)        begin fails++; $display("FAIL reset_q got %b want 0", q); end
      tests++; if (spiked !== 1'b0)   begin fails++; $display("FAIL reset_spiked got %b want 0", spiked); end
      tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      @(posedge aclk); #1;
      grst = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      tests++; if (busy !== 1'b0 || q !== 1'b0) begin
         fails++; $display("FAIL idle_hold busy=%b q=%b want 0 0", busy, q);
      end
      @(posedge aclk); #1;
   endtask

   task automatic test_delay_v3();
      do_load(5'd3);
      @(negedge aclk);
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL load_full in_ready got %b want 0", in_ready); end
      @(posedge aclk); #1;
      rst_capture(20, 1'b0, 5'd0);
      tests++; if (rh[1] !== 1'b1) begin fails++; $display("FAIL v3_in_ready_c1 got %b want 1", rh[1]); end
      for (int k = 1; k <= 20; k++) begin
         tests++; if (qh[k] !== exp_q(k, 3)) begin
            fails++; $display("FAIL v3_q k=%0d got %b want %b", k, qh[k], exp_q(k, 3));
         end
         tests++; if (sh[k] !== exp_spk(k, 3)) begin
            fails++; $display("FAIL v3_spiked k=%0d got %b want %b", k, sh[k], exp_spk(k, 3));
         end
         tests++; if (bh[k] !== exp_busy(k, 3)) begin
            fails++; $display("FAIL v3_busy k=%0d got %b want %b", k, bh[k], exp_busy(k, 3));
         end
      end
   endtask

   task automatic test_boundaries();
      do_load(5'd0);
      rst_capture(12, 1'b0, 5'd0);
      for (int k = 1; k <= 12; k++) begin
         tests++; if (qh[k] !== exp_q(k, 0)) begin
            fails++; $display("FAIL v0_q k=%0d got %b want %b", k, qh[k], exp_q(k, 0));
         end
      end
      tests++; if (sh[1] !== 1'b1) begin fails++; $display("FAIL v0_spiked_c1 got %b want 1", sh[1]); end
      do_load(5'd12);
      rst_capture(20, 1'b0, 5'd0);
      for (int k = 1; k <= 20; k++) begin
         tests++; if (qh[k] !== exp_q(k, 12)) begin
            fails++; $display("FAIL v12_q k=%0d got %b want %b", k, qh[k], exp_q(k, 12));
         end
         tests++; if (bh[k] !== exp_busy(k, 12)) begin
            fails++; $display("FAIL v12_busy k=%0d got %b want %b", k, bh[k], exp_busy(k, 12));
         end
      end
   endtask

   task automatic test_infinity();
      do_load(5'd16);
      rst_capture(20, 1'b0, 5'd0);
      for (int k = 1; k <= 20; k++) begin
         tests++; if (qh[k] !== 1'b0 || sh[k] !== 1'b0) begin
            fails++; $display("FAIL inf_quiet k=%0d q=%b spiked=%b want 0 0", k, qh[k], sh[k]);
         end
         tests++; if (bh[k] !== exp_busy(k, 16)) begin
            fails++; $display("FAIL inf_busy k=%0d got %b want %b", k, bh[k], exp_busy(k, 16));
         end
      end
   endtask

   task automatic test_mid_rst();
      do_load(5'd5);
      do_rst();
      do_load(5'd2);
      repeat (5) begin @(posedge aclk); #1; end
      tests++; if (q !== 1'b1) begin fails++; $display("FAIL mid_q_slot6 got %b want 1", q); end
      rst_capture(8, 1'b0, 5'd0);
      for (int k = 1; k <= 8; k++) begin
         tests++; if (qh[k] !== exp_q(k, 2)) begin
            fails++; $display("FAIL mid_q k=%0d got %b want %b", k, qh[k], exp_q(k, 2));
         end
         tests++; if (sh[k] !== exp_spk(k, 2)) begin
            fails++; $display("FAIL mid_spiked k=%0d got %b want %b", k, sh[k], exp_spk(k, 2));
         end
      end
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1;
      in_value = 5'd7;
      @(posedge aclk); #1;
      in_value = 5'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         tests++; if (in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_in_ready cyc=%0d got %b want 0", i, in_ready);
         end
         @(posedge aclk); #1;
      end
      in_valid = 1'b0;
      rst_capture(18, 1'b0, 5'd0);
      for (int k = 1; k <= 18; k++) begin
         tests++; if (qh[k] !== exp_q(k, 7)) begin
            fails++; $display("FAIL bp_q k=%0d got %b want %b", k, qh[k], exp_q(k, 7));
         end
      end
   endtask

   task automatic test_same_cycle();
      rst_capture(17, 1'b1, 5'd1);
      tests++; if (rh[1] !== 1'b0) begin fails++; $display("FAIL sc_in_ready_c1 got %b want 0", rh[1]); end
      for (int k = 1; k <= 17; k++) begin
         tests++; if (qh[k] !== 1'b0 || sh[k] !== 1'b0) begin
            fails++; $display("FAIL sc_current_quiet k=%0d q=%b spiked=%b want 0 0", k, qh[k], sh[k]);
         end
      end
      rst_capture(6, 1'b0, 5'd0);
      tests++; if (rh[1] !== 1'b1) begin fails++; $display("FAIL sc_drain_in_ready got %b want 1", rh[1]); end
      for (int k = 1; k <= 6; k++) begin
         tests++; if (qh[k] !== exp_q(k, 1)) begin
            fails++; $display("FAIL sc_next_q k=%0d got %b want %b", k, qh[k], exp_q(k, 1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_delay_v3();
      test_boundaries();
      test_infinity();
      test_mid_rst();
      test_backpressure();
      test_same_cycle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/temporal_encoder.md
# temporal_encoder

Converts a binary value into a single temporal event inside one gamma cycle: the output rises exactly `value` aclk cycles after the gamma-cycle start strobe. It is the source side of the race-logic fabric. Its output drives the pulse inputs of the min, max and exclusive-min primitives. A one-entry pending buffer lets the next gamma cycle's value be loaded while the current event is in flight.

## Interface
- GAMMA_CYCLE_WIDTH, 16: aclk cycles per gamma cycle; time slots 0..GAMMA_CYCLE_WIDTH-1.
- PULSE_WIDTH, 8: q high time in cycles (pulse mode).
- VALUE_WIDTH, $clog2(GAMMA_CYCLE_WIDTH)+1: width of in_value; values ≥ GAMMA_CYCLE_WIDTH mean "infinity" (no event).
- aclk  in  1  clock.
- grst  in  1  reset, asynchronous, active-high.
- rst  in  1  gamma-cycle start strobe, synchronous, one cycle.
- in_valid  in  1  producer offers in_value.
- in_ready  out  1  pending buffer empty.
- in_value  in  VALUE_WIDTH  event time for a following gamma cycle.
- q  out  1  temporal output.
- spiked  out  1  an event has fired in the current gamma cycle; sticky until next rst.
- busy  out  1  state is WAIT or PULSE.

## Operation
- Reset (grst) values: q=0, spiked=0, busy=0, in_ready=1. State IDLE, pending buffer empty, active value = infinity.
- Handshake:
  - A transfer occurs on a cycle with in_valid && in_ready.
  - in_ready depends only on pending-buffer occupancy, never on in_valid.
  - Once a value is accepted, the pending buffer is full and in_ready goes low next cycle.
- On rst:
  - If the pending buffer is full, its value moves to active and the buffer empties.
  - If the buffer is empty, active becomes infinity.
  - A transfer in the same cycle as rst loads the pending buffer for the next gamma cycle. There is no bypass to active.
- States:
  - IDLE: before the first rst. Only leaves on rst.
  - WAIT: counting time toward the active value.
  - PULSE: q high.
  - DONE: event finished, or value is infinity. Waits for rst.
- rst from any state restarts: the gamma counter t reloads to 0, spiked clears, and any pulse in progress is aborted.
- Event when t == active value: q is asserted and spiked is set.
- An infinity value never fires; the block goes from WAIT to DONE at the end of the gamma cycle.
- The gamma counter is $clog2(GAMMA_CYCLE_WIDTH) bits. It stops at GAMMA_CYCLE_WIDTH-1 and does not wrap.

## Timing
- rst sampled in cycle C0 gives t=0 in cycle C0+1.
- q is registered. It is first high in cycle C0+1+v, so v=0 raises q in the cycle right after rst.
- Pulse mode: q is high for PULSE_WIDTH cycles, C0+1+v..C0+v+PULSE_WIDTH.
  - The pulse is truncated at the end of the gamma cycle (slot GAMMA_CYCLE_WIDTH-1 is the last high cycle); then state DONE.
- spiked rises in the same cycle q first rises.
- Mid-event rst: q in cycle C0+1 equals (new active value == 0). Otherwise q is low.
- A rst before slot v suppresses the old event entirely.
- in_ready rises the cycle after the rst that drains the pending buffer.

## Configuration
- TE_LEVEL_HOLD_EN defined (step encoding, rising-edge race logic):
  - q rises at C0+1+v and stays high through DONE.
  - q clears only on the next rst (or grst).
  - PULSE_WIDTH is unused and there is no PULSE truncation.
- Undefined (default): fixed-width pulse mode as described above.

## Structure
- Shared package `temporal_pkg`:
  - state enum `te_state_t` (IDLE, WAIT, PULSE, DONE).
  - function `is_inf(value)`.
  - localparam helper for the gamma counter width.
- Sub-module `gamma_counter`:
  - loads 0 on rst and increments to GAMMA_CYCLE_WIDTH-1, then holds.
  - outputs t and last_slot.
  - intended for reuse by the temporal decoder.
- The pending buffer, FSM and pulse-length counter ($clog2(PULSE_WIDTH+1) bits) stay in temporal_encoder.

## Test plan
- grst, then load v=3 and pulse rst at C0 → q high in cycles C0+4..C0+11 (8 cycles), spiked from C0+4, in_ready=1 at C0+1.
- Load v=0 and pulse rst → q high at C0+1. Load v=12 → q high for slots 12..15 only (4 cycles), then DONE with q=0.
- Load v=16 (infinity) → q never rises and spiked stays 0 for the whole gamma cycle.
- Load v=5, rst, then load v=2 while q is high at slot 6 and assert rst again → q low the cycle after the second rst, then high again 2 cycles after that.
- Hold in_valid with the buffer full → in_ready=0, no overwrite. Transfer in the same cycle as rst → the value is used in the following gamma cycle, not the current one.
- TE_LEVEL_HOLD_EN build, v=3 → q high from C0+4 until the cycle after the next rst.
